// File: rtl/keypad_col_if.sv
// Keypad column-reader bus: row drive and raw columns in, sweep pacing and key code out.
// key_held exists only when KEYPAD_HELD_EN is defined.
interface keypad_col_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       scan_en;
   logic [3:0] key;
   logic       key_valid;
`ifdef KEYPAD_HELD_EN
   logic       key_held;

   modport master (
      input  rows,
      input  cols,
      output scan_en,
      output key,
      output key_valid,
      output key_held
   );

   modport slave (
      output rows,
      output cols,
      input  scan_en,
      input  key,
      input  key_valid,
      input  key_held
   );
`else
   modport master (
      input  rows,
      input  cols,
      output scan_en,
      output key,
      output key_valid
   );

   modport slave (
      output rows,
      output cols,
      input  scan_en,
      input  key,
      input  key_valid
   );
`endif
endinterface

// File: rtl/keypad_col_reader.sv
// Column-side reader for a 4x4 matrix keypad: paces the row sweep, debounces columns, emits hex key codes.
// Optional key_held output is built when KEYPAD_HELD_EN is defined.
module keypad_col_reader #(
   parameter int SCAN_PERIOD     = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic         clk,
   input  logic         reset,
   keypad_col_if.master kp
);

   localparam int CNT_MAX = (SCAN_PERIOD > DEBOUNCE_CYCLES) ? SCAN_PERIOD : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SCAN_TC = CNT_W'(SCAN_PERIOD - 1);
   localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE_DB
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [3:0]       cs_p0;
   logic [3:0]       cs_p1;
   logic [3:0]       cs;
   logic [1:0]       row_lat;
   logic [1:0]       col_lat;
   logic             col_hit;
   logic             capture;
   logic             accept;
   logic             scan_en_q;
   logic             scan_en_nx;
   logic             key_valid_q;
   logic             key_valid_nx;
   logic [3:0]       key_q;

   function automatic logic [1:0] lowest_idx(input logic [3:0] v);
      logic [1:0] idx;
      casez (v)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [3:0] key_encode(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // stage p0/p1: two-flop column synchroniser
   always_ff @(posedge clk) begin
      if (!reset) begin
         cs_p0 <= 4'b0;
         cs_p1 <= 4'b0;
      end else begin
         cs_p0 <= kp.cols;
         cs_p1 <= cs_p0;
      end
   end

   assign cs      = cs_p1;
   assign col_hit = cs[col_lat];

   // Bounce-back checks are evaluated ahead of the terminal-count compare.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt + 1'b1;
      scan_en_nx   = 1'b0;
      key_valid_nx = 1'b0;
      capture      = 1'b0;
      accept       = 1'b0;
      case (state)
         ST_SCAN: begin
            if (cnt == SCAN_TC) begin
               cnt_nx = '0;
               if ((cs != 4'b0) && (kp.rows != 4'b0)) begin
                  capture  = 1'b1;
                  state_nx = ST_DEBOUNCE;
               end else begin
                  scan_en_nx = 1'b1;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (!col_hit) begin
               state_nx = ST_SCAN;
               cnt_nx   = '0;
            end else if (cnt == DB_TC) begin
               accept       = 1'b1;
               key_valid_nx = 1'b1;
               state_nx     = ST_PRESSED;
               cnt_nx       = '0;
            end
         end
         ST_PRESSED: begin
            cnt_nx = '0;
            if (!col_hit) begin
               state_nx = ST_RELEASE_DB;
            end
         end
         ST_RELEASE_DB: begin
            if (col_hit) begin
               state_nx = ST_PRESSED;
               cnt_nx   = '0;
            end else if (cnt == DB_TC) begin
               state_nx = ST_SCAN;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = ST_SCAN;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_SCAN;
         cnt         <= '0;
         scan_en_q   <= 1'b0;
         key_valid_q <= 1'b0;
         key_q       <= 4'h0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         scan_en_q   <= scan_en_nx;
         key_valid_q <= key_valid_nx;
         if (accept) begin
            key_q <= key_encode(row_lat, col_lat);
         end
      end
   end

   // Row/column indices are only consulted after a capture has loaded them.
   always_ff @(posedge clk) begin
      if (capture) begin
         row_lat <= lowest_idx(kp.rows);
         col_lat <= lowest_idx(cs);
      end
   end

   assign kp.scan_en   = scan_en_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key       = key_q;

`ifdef KEYPAD_HELD_EN
   logic key_held_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         key_held_q <= 1'b0;
      end else begin
         key_held_q <= (state_nx == ST_PRESSED) || (state_nx == ST_RELEASE_DB);
      end
   end

   assign kp.key_held = key_held_q;
`endif

endmodule

// File: tb/tb_keypad_col_reader.sv
// Directed bench for keypad_col_reader with SCAN_PERIOD=4, DEBOUNCE_CYCLES=8.
// Define KEYPAD_HELD_EN to also exercise key_held.
module tb_keypad_col_reader;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   keypad_col_if kp();

   keypad_col_reader #(
      .SCAN_PERIOD     (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in SCAN with cnt=0; the next step is edge 1.
   task automatic apply_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      kp.rows = 4'b0000;
      kp.cols = 4'hF;
      reset   = 1'b0;
      repeat (3) step();
      n_tests++;
      if ({kp.scan_en, kp.key_valid, kp.key} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset se/kv/key got %b want 000000", {kp.scan_en, kp.key_valid, kp.key});
      end
`ifdef KEYPAD_HELD_EN
      n_tests++;
      if (kp.key_held !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held got %b want 0", kp.key_held);
      end
`endif
   endtask

   task automatic test_idle();
      kp.rows = 4'b0001;
      kp.cols = 4'b0000;
      apply_reset();
      for (int k = 1; k <= 40; k++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {(k % 4 == 0), 1'b0}) begin
            n_fail++;
            $display("FAIL idle cyc=%0d se/kv got %b want %b", k, {kp.scan_en, kp.key_valid},
                     {(k % 4 == 0), 1'b0});
         end
      end
   endtask

   task automatic test_clean_press();
      kp.rows = 4'b0010;
      kp.cols = 4'b0100;
      apply_reset();
      for (int i = 1; i <= 20; i++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {1'b0, (i == 12)}) begin
            n_fail++;
            $display("FAIL press cyc=%0d se/kv got %b want %b", i, {kp.scan_en, kp.key_valid},
                     {1'b0, (i == 12)});
         end
         if (i == 12) begin
            n_tests++;
            if (kp.key !== 4'h6) begin
               n_fail++;
               $display("FAIL press_key got %h want 6", kp.key);
            end
         end
      end
      kp.cols = 4'b0000;
      for (int j = 1; j <= 16; j++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {(j == 15), 1'b0}) begin
            n_fail++;
            $display("FAIL release cyc=%0d se/kv got %b want %b", j, {kp.scan_en, kp.key_valid},
                     {(j == 15), 1'b0});
         end
`ifdef KEYPAD_HELD_EN
         n_tests++;
         if (kp.key_held !== (j < 11)) begin
            n_fail++;
            $display("FAIL release_held cyc=%0d got %b want %b", j, kp.key_held, (j < 11));
         end
`endif
      end
      n_tests++;
      if (kp.key !== 4'h6) begin
         n_fail++;
         $display("FAIL key_hold got %h want 6", kp.key);
      end
   endtask

   task automatic test_bounce();
      logic hi;
      kp.rows = 4'b1000;
      kp.cols = 4'b0010;
      apply_reset();
      for (int i = 1; i <= 30; i++) begin
         step();
         hi = (i <= 2) || (i >= 9 && i <= 11) || (i >= 15 && i <= 17);
         kp.cols = hi ? 4'b0010 : 4'b0000;
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {(i == 10 || i == 25 || i == 29), 1'b0}) begin
            n_fail++;
            $display("FAIL bounce cyc=%0d se/kv got %b want %b", i, {kp.scan_en, kp.key_valid},
                     {(i == 10 || i == 25 || i == 29), 1'b0});
         end
      end
   endtask

   task automatic test_glitch_final();
      kp.rows = 4'b0100;
      kp.cols = 4'b1000;
      apply_reset();
      for (int i = 1; i <= 26; i++) begin
         step();
         kp.cols = (i == 9) ? 4'b0000 : 4'b1000;
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {1'b0, (i == 24)}) begin
            n_fail++;
            $display("FAIL glitch_db cyc=%0d se/kv got %b want %b", i, {kp.scan_en, kp.key_valid},
                     {1'b0, (i == 24)});
         end
         if (i == 24) begin
            n_tests++;
            if (kp.key !== 4'hC) begin
               n_fail++;
               $display("FAIL glitch_key got %h want C", kp.key);
            end
         end
      end
   endtask

   task automatic test_release_bounce();
      kp.rows = 4'b0010;
      kp.cols = 4'b0100;
      apply_reset();
      for (int i = 1; i <= 14; i++) begin
         step();
         n_tests++;
         if (kp.key_valid !== (i == 12)) begin
            n_fail++;
            $display("FAIL rb_press cyc=%0d kv got %b want %b", i, kp.key_valid, (i == 12));
         end
      end
      // five low cycles, then back high
      kp.cols = 4'b0000;
      for (int j = 1; j <= 15; j++) begin
         step();
         kp.cols = (j <= 4) ? 4'b0000 : 4'b0100;
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rb_short cyc=%0d se/kv got %b want 00", j, {kp.scan_en, kp.key_valid});
         end
`ifdef KEYPAD_HELD_EN
         n_tests++;
         if (kp.key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL rb_held cyc=%0d got %b want 1", j, kp.key_held);
         end
`endif
      end
      // glitch high on the final release-debounce cycle
      kp.cols = 4'b0000;
      for (int k = 1; k <= 20; k++) begin
         step();
         kp.cols = (k <= 7) ? 4'b0000 : 4'b0100;
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rb_final cyc=%0d se/kv got %b want 00", k, {kp.scan_en, kp.key_valid});
         end
      end
      kp.cols = 4'b0000;
      for (int m = 1; m <= 16; m++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {(m == 15), 1'b0}) begin
            n_fail++;
            $display("FAIL rb_resume cyc=%0d se/kv got %b want %b", m, {kp.scan_en, kp.key_valid},
                     {(m == 15), 1'b0});
         end
      end
   endtask

   task automatic test_multi_key();
      kp.rows = 4'b0001;
      kp.cols = 4'b1010;
      apply_reset();
      for (int i = 1; i <= 14; i++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== {1'b0, (i == 12)}) begin
            n_fail++;
            $display("FAIL multi cyc=%0d se/kv got %b want %b", i, {kp.scan_en, kp.key_valid},
                     {1'b0, (i == 12)});
         end
      end
      n_tests++;
      if (kp.key !== 4'h2) begin
         n_fail++;
         $display("FAIL multi_key got %h want 2", kp.key);
      end
      kp.cols = 4'b1011;
      for (int n = 1; n <= 12; n++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid, kp.key} !== 6'b00_0010) begin
            n_fail++;
            $display("FAIL rollover cyc=%0d se/kv/key got %b want 000010", n,
                     {kp.scan_en, kp.key_valid, kp.key});
         end
      end
   endtask

   task automatic test_reset_mid();
      kp.rows = 4'b0010;
      kp.cols = 4'b0100;
      apply_reset();
      repeat (12) step();
      n_tests++;
      if ({kp.key_valid, kp.key} !== 5'b1_0110) begin
         n_fail++;
         $display("FAIL rm_press kv/key got %b want 10110", {kp.key_valid, kp.key});
      end
      kp.cols = 4'b0000;
      repeat (11) step();
      kp.cols = 4'b0100;
      for (int p = 1; p <= 9; p++) begin
         step();
         n_tests++;
         if ({kp.scan_en, kp.key_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rm_db cyc=%0d se/kv got %b want 00", p, {kp.scan_en, kp.key_valid});
         end
      end
      reset = 1'b0;
      step();
      n_tests++;
      if ({kp.scan_en, kp.key_valid, kp.key} !== 6'b0) begin
         n_fail++;
         $display("FAIL rm_reset se/kv/key got %b want 000000", {kp.scan_en, kp.key_valid, kp.key});
      end
`ifdef KEYPAD_HELD_EN
      n_tests++;
      if (kp.key_held !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_held got %b want 0", kp.key_held);
      end
`endif
      reset = 1'b1;
      for (int q = 1; q <= 10; q++) begin
         step();
         n_tests++;
         if ({kp.key_valid, kp.key} !== 5'b0) begin
            n_fail++;
            $display("FAIL rm_after cyc=%0d kv/key got %b want 00000", q, {kp.key_valid, kp.key});
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      kp.rows = 4'b0000;
      kp.cols = 4'b0000;
      test_reset();
      test_idle();
      test_clean_press();
      test_bounce();
      test_glitch_final();
      test_release_bounce();
      test_multi_key();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
